// File: rtl/axi4_lite_arb2_if.sv
// ----------------------------------------------------------------------------
// axi4_lite_if
// AXI4-Lite channel bundle used by axi4_lite_arb2 and its environment.
//   Parameters : AXI_ALEN (address width), AXI_DLEN (data width, strobe = /8)
//   Modport M  : master view  (drives AW/W/AR valid+payload, B/R ready)
//   Modport S  : slave view   (drives AW/W/AR ready, B/R valid+payload)
// ----------------------------------------------------------------------------
interface axi4_lite_if #(
    parameter int AXI_ALEN = 64,
    parameter int AXI_DLEN = 64
) ();
    localparam int STRB_W = AXI_DLEN / 8;

    logic                awvalid;
    logic                awready;
    logic [AXI_ALEN-1:0] awaddr;
    logic [2:0]          awprot;

    logic                wvalid;
    logic                wready;
    logic [AXI_DLEN-1:0] wdata;
    logic [STRB_W-1:0]   wstrb;

    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;

    logic                arvalid;
    logic                arready;
    logic [AXI_ALEN-1:0] araddr;
    logic [2:0]          arprot;

    logic                rvalid;
    logic                rready;
    logic [AXI_DLEN-1:0] rdata;
    logic [1:0]          rresp;

    modport M (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport S (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_arb2.sv
// ----------------------------------------------------------------------------
// axi4_lite_arb2
// Two-master to one-slave AXI4-Lite arbiter. One complete transaction
// (address, data, response) is in flight at a time; the winner's channels are
// forwarded to the shared slave and the other master is held off.
//   clk     : system clock, rising edge
//   rstn    : asynchronous active-low reset
//   s0, s1  : upstream ports (arbiter is the slave), master 0 / master 1
//   m       : downstream port to the shared slave (arbiter is the master)
//   o_grant : one-hot current owner, 2'b00 when idle
//   o_busy  : high whenever the FSM is not IDLE
// Build option:
//   ARB_FIXED_PRIO_EN : master 0 always wins a tie; no last-winner register.
//                       Undefined (default): round-robin between the masters.
// ----------------------------------------------------------------------------
module axi4_lite_arb2 #(
    parameter int AXI_ALEN = 64,
    parameter int AXI_DLEN = 64
) (
    input  logic          clk,
    input  logic          rstn,
    axi4_lite_if.S        s0,
    axi4_lite_if.S        s1,
    axi4_lite_if.M        m,
    output logic [1:0]    o_grant,
    output logic          o_busy
);
    localparam int STRB_W = AXI_DLEN / 8;

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_RESP,
        R_ADDR,
        R_DATA
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
`ifndef ARB_FIXED_PRIO_EN
    logic   last_q, last_d;
`endif

    // Request decode and arbitration
    logic wreq0, wreq1, req0, req1;
    logic win, win_wreq;

    assign wreq0 = s0.awvalid | s0.wvalid;
    assign wreq1 = s1.awvalid | s1.wvalid;
    assign req0  = wreq0 | s0.arvalid;
    assign req1  = wreq1 | s1.arvalid;

    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~last_q;
`endif
        end else begin
            win = req1;
        end
        win_wreq = win ? wreq1 : wreq0;
    end

    // Selected upstream master; payload follows s0 while idle
    logic                sel;
    logic                sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic [AXI_ALEN-1:0] sel_awaddr, sel_araddr;
    logic [2:0]          sel_awprot, sel_arprot;
    logic [AXI_DLEN-1:0] sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;

    assign sel = (state_q == IDLE) ? 1'b0 : owner_q;

    always_comb begin
        sel_awvalid = sel ? s1.awvalid : s0.awvalid;
        sel_awaddr  = sel ? s1.awaddr  : s0.awaddr;
        sel_awprot  = sel ? s1.awprot  : s0.awprot;
        sel_wvalid  = sel ? s1.wvalid  : s0.wvalid;
        sel_wdata   = sel ? s1.wdata   : s0.wdata;
        sel_wstrb   = sel ? s1.wstrb   : s0.wstrb;
        sel_bready  = sel ? s1.bready  : s0.bready;
        sel_arvalid = sel ? s1.arvalid : s0.arvalid;
        sel_araddr  = sel ? s1.araddr  : s0.araddr;
        sel_arprot  = sel ? s1.arprot  : s0.arprot;
        sel_rready  = sel ? s1.rready  : s0.rready;
    end

    // Downstream valids depend only on registered state and upstream valids,
    // never on m-side readies.
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = m.awvalid & m.awready;
    assign w_hs  = m.wvalid  & m.wready;
    assign b_hs  = m.bvalid  & m.bready;
    assign ar_hs = m.arvalid & m.arready;
    assign r_hs  = m.rvalid  & m.rready;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = win;
                    state_d = win_wreq ? W_ADDR : R_ADDR;
                end
            end
            W_ADDR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q  | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
`ifndef ARB_FIXED_PRIO_EN
                    last_d  = owner_q;
`endif
                end
            end
            R_ADDR: begin
                if (ar_hs) state_d = R_DATA;
            end
            R_DATA: begin
                if (r_hs) begin
                    state_d = IDLE;
`ifndef ARB_FIXED_PRIO_EN
                    last_d  = owner_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel forwarding
    logic aw_fwd, w_fwd;
    assign aw_fwd = (state_q == W_ADDR) && !aw_done_q;
    assign w_fwd  = (state_q == W_ADDR) && !w_done_q;

    always_comb begin
        m.awvalid  = aw_fwd && sel_awvalid;
        m.awaddr   = sel_awaddr;
        m.awprot   = sel_awprot;
        m.wvalid   = w_fwd && sel_wvalid;
        m.wdata    = sel_wdata;
        m.wstrb    = sel_wstrb;
        m.bready   = (state_q == W_RESP) && sel_bready;
        m.arvalid  = (state_q == R_ADDR) && sel_arvalid;
        m.araddr   = sel_araddr;
        m.arprot   = sel_arprot;
        m.rready   = (state_q == R_DATA) && sel_rready;

        s0.awready = aw_fwd && !owner_q && m.awready;
        s1.awready = aw_fwd &&  owner_q && m.awready;
        s0.wready  = w_fwd  && !owner_q && m.wready;
        s1.wready  = w_fwd  &&  owner_q && m.wready;
        s0.bvalid  = (state_q == W_RESP) && !owner_q && m.bvalid;
        s1.bvalid  = (state_q == W_RESP) &&  owner_q && m.bvalid;
        s0.arready = (state_q == R_ADDR) && !owner_q && m.arready;
        s1.arready = (state_q == R_ADDR) &&  owner_q && m.arready;
        s0.rvalid  = (state_q == R_DATA) && !owner_q && m.rvalid;
        s1.rvalid  = (state_q == R_DATA) &&  owner_q && m.rvalid;

        s0.bresp   = m.bresp;
        s1.bresp   = m.bresp;
        s0.rdata   = m.rdata;
        s1.rdata   = m.rdata;
        s0.rresp   = m.rresp;
        s1.rresp   = m.rresp;
    end

    assign o_busy  = (state_q != IDLE);
    assign o_grant = o_busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end
endmodule

// File: doc/axi4_lite_arb2.md
# axi4_lite_arb2

Two-master to one-slave AXI4-Lite arbiter that shares a single peripheral port (the GPIO/LED register block) between two requesters, e.g. the host bridge and an on-board pattern sequencer. It runs one complete transaction at a time: address, data and response, write or read. It selects the next master by round-robin and forwards the winner's channels to the slave while holding the loser off.

## Interface
- AXI_ALEN, 64, address width of all three interfaces.
- AXI_DLEN, 64, data width; strobe width is AXI_DLEN/8.
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  reset, asynchronous assert, active-low.
- s0  axi4_lite_if.S  —  upstream port, master 0.
- s1  axi4_lite_if.S  —  upstream port, master 1.
- m  axi4_lite_if.M  —  downstream port to the shared slave.
- o_grant  output  2  one-hot current owner; 2'b00 when idle.
- o_busy  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, W_ADDR, W_RESP, R_ADDR, R_DATA. State, owner index, last-winner pointer and the aw_done/w_done flags are registers. Channel forwarding is combinational from the registered state.
- Request per master: wreq = awvalid | wvalid; rreq = arvalid.
- IDLE: if no master has any request, stay in IDLE. Otherwise choose the owner:
  - If only one master requests, it wins.
  - If both request, the master that did not win last wins (round-robin).
  - For the winning master, a write beats a read. Go to W_ADDR or R_ADDR.
- W_ADDR: owner AW and W are forwarded to m independently. Set aw_done on the AW handshake and w_done on the W handshake. Once both are done (handshakes in the same or different cycles), clear the flags and go to W_RESP. After its handshake, a channel's valid to m and its ready to the owner are forced to 0.
- W_RESP: forward m.bvalid/bresp to the owner and owner bready to m. On the B handshake go to IDLE and set last-winner to the owner.
- R_ADDR: forward AR. On the AR handshake go to R_DATA.
- R_DATA: forward rvalid/rdata/rresp to the owner and rready to m. On the R handshake go to IDLE and update last-winner.
- Non-owner and IDLE: all readys/valids toward the upstream ports are 0, and all valids to m are 0. Payload fields to m follow s0 while idle (don't-care).
- bresp/rresp pass through unmodified (OKAY/SLVERR/DECERR).
- Reset mid-transaction: state goes to IDLE immediately and the transaction is abandoned. The system resets slave and masters on the same rstn.

## Timing
- Reset values:
  - State IDLE, last-winner = 1 (so master 0 wins the first tie).
  - o_grant 0, o_busy 0.
  - All m.*valid, m.bready, m.rready = 0.
  - All s*.awready/wready/arready/bvalid/rvalid = 0.
- Arbitration latency: 1 cycle. A request seen in IDLE at cycle N is forwarded to m at N+1.
- No combinational path from m ready back to m valid.
- Back-to-back transactions: at least one IDLE cycle between the response handshake and the next forward. Peak rate is one transaction per (slave latency + 2) cycles.
- A request that loses arbitration keeps its valid asserted (AXI rule). The arbiter never drops a granted valid before its handshake.

## Configuration
- ARB_FIXED_PRIO_EN defined: master 0 always wins a tie. The last-winner register is not implemented, and master 1 can be starved.
- ARB_FIXED_PRIO_EN undefined: round-robin as above (default).

## Test plan
- Single write from s0: awaddr=0x0, wdata=0xA5, wstrb=0x01, slave ready after 1 cycle -> s0 sees bresp=OKAY; slave register shows 0xA5; o_grant=01 during the transfer, then 00.
- Simultaneous writes, s0 data 0x11 and s1 data 0x22, after reset -> s0 is served first, then s1. Final register is 0x22. Two B responses, one per master, none crossed.
- Continuous requests from both masters for 8 transactions -> grants alternate 01,10,01,... With ARB_FIXED_PRIO_EN defined, all 8 go to s0.
- s1 sends W 3 cycles before AW; s0 requests a read 1 cycle later -> the s1 write completes first. The s0 read then returns rdata[7:0]=the s1 value, with rresp OKAY.
- Read with an invalid address from s0 -> slave DECERR (2'b11) is passed to s0.rresp unchanged; s1 sees no rvalid.
- rstn pulsed low while in W_RESP -> o_busy and all valid outputs go to 0 asynchronously. After release, the first request is granted normally.
